// File: rtl/cache_miss_fill_controller.sv
// cache_miss_fill_controller
// Miss-service sequencer: asks the replacement policy for a victim line,
// writes a dirty victim back to memory, fetches the missing block, fills the
// data array and commits the new tag.
// Optional build macro: MISS_FILL_STATS_EN adds saturating miss/writeback
// counters on stat_miss_o / stat_wb_o.
module cache_miss_fill_controller #(
   parameter  int CACHE_BLOCK_CAPACITY = 128,
   parameter  int BLOCK_WORDS          = 4,
   parameter  int BW_TAG               = 24,
   parameter  int BW_WORD              = 32,
   localparam int BW_LINE              = $clog2(CACHE_BLOCK_CAPACITY),
   localparam int BW_OFF               = $clog2(BLOCK_WORDS)
) (
   input  logic                      clock_i,
   input  logic                      resetn_i,
   // cache controller side
   input  logic                      miss_i,
   input  logic [BW_TAG-1:0]         miss_tag_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [BW_LINE-1:0]        line_o,
   // replacement policy side
   output logic                      policy_miss_o,
   input  logic                      policy_done_i,
   input  logic [BW_LINE-1:0]        policy_addr_i,
   // tag RAM
   output logic                      tag_rd_o,
   input  logic                      victim_valid_i,
   input  logic                      victim_dirty_i,
   input  logic [BW_TAG-1:0]         victim_tag_i,
   output logic                      tag_wr_o,
   output logic [BW_TAG-1:0]         tag_o,
   // data array
   output logic [BW_LINE+BW_OFF-1:0] cache_addr_o,
   output logic                      cache_rd_o,
   input  logic [BW_WORD-1:0]        cache_data_i,
   output logic                      cache_wr_o,
   output logic [BW_WORD-1:0]        cache_data_o,
   // memory port
   output logic                      mem_req_o,
   output logic                      mem_rw_o,
   output logic [BW_TAG+BW_OFF-1:0]  mem_addr_o,
   output logic [BW_WORD-1:0]        mem_data_o,
   input  logic                      mem_ready_i,
   input  logic                      mem_valid_i,
   input  logic [BW_WORD-1:0]        mem_data_i
`ifdef MISS_FILL_STATS_EN
   ,
   output logic [31:0]               stat_miss_o,
   output logic [31:0]               stat_wb_o
`endif
);

   localparam logic [BW_OFF-1:0] LAST_WORD = BW_OFF'(BLOCK_WORDS - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_POL,
      S_POL_WAIT,
      S_TAG_RD,
      S_TAG_CHK,
      S_WB_RD,
      S_WB_WR,
      S_FETCH,
      S_FILL,
      S_COMMIT,
      S_DONE
   } state_t;

   state_t              state;
   logic [BW_OFF-1:0]   cnt;
   logic [BW_TAG-1:0]   miss_tag_q;
   logic [BW_TAG-1:0]   victim_tag_q;
   logic [BW_WORD-1:0]  wb_data_q;
   logic                wb_first;

   // The data array answers one cycle after cache_rd_o, i.e. in the first
   // WB_WR cycle; that word is forwarded straight through and also held so
   // the write data stays stable for as long as memory stalls.
   assign mem_data_o   = (state == S_WB_WR) ? (wb_first ? cache_data_i : wb_data_q) : '0;

   // Fill writes track mem_valid_i in the same cycle, so they are decoded here.
   assign cache_wr_o   = (state == S_FILL) && mem_valid_i;
   assign cache_data_o = cache_wr_o ? mem_data_i : '0;
   assign cache_addr_o = {line_o, cnt};
   assign tag_o        = miss_tag_q;

   // Miss-service sequencer with registered strobes and memory request.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state         <= S_IDLE;
         cnt           <= '0;
         miss_tag_q    <= '0;
         victim_tag_q  <= '0;
         wb_data_q     <= '0;
         wb_first      <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         line_o        <= '0;
         policy_miss_o <= 1'b0;
         tag_rd_o      <= 1'b0;
         tag_wr_o      <= 1'b0;
         cache_rd_o    <= 1'b0;
         mem_req_o     <= 1'b0;
         mem_rw_o      <= 1'b0;
         mem_addr_o    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (miss_i) begin
                  miss_tag_q    <= miss_tag_i;
                  busy_o        <= 1'b1;
                  policy_miss_o <= 1'b1;
                  state         <= S_POL;
               end
            end

            // policy_done_i is deliberately not looked at here: the policy
            // controller cannot have answered a pulse it has only just seen.
            S_POL: begin
               policy_miss_o <= 1'b0;
               state         <= S_POL_WAIT;
            end

            S_POL_WAIT: begin
               if (policy_done_i) begin
                  line_o   <= policy_addr_i;
                  tag_rd_o <= 1'b1;
                  state    <= S_TAG_RD;
               end
            end

            S_TAG_RD: begin
               tag_rd_o <= 1'b0;
               state    <= S_TAG_CHK;
            end

            S_TAG_CHK: begin
               if (victim_valid_i && victim_dirty_i) begin
                  victim_tag_q <= victim_tag_i;
                  cnt          <= '0;
                  cache_rd_o   <= 1'b1;
                  state        <= S_WB_RD;
               end else begin
                  mem_req_o  <= 1'b1;
                  mem_rw_o   <= 1'b0;
                  mem_addr_o <= {miss_tag_q, {BW_OFF{1'b0}}};
                  state      <= S_FETCH;
               end
            end

            S_WB_RD: begin
               cache_rd_o <= 1'b0;
               mem_req_o  <= 1'b1;
               mem_rw_o   <= 1'b1;
               mem_addr_o <= {victim_tag_q, cnt};
               wb_first   <= 1'b1;
               state      <= S_WB_WR;
            end

            S_WB_WR: begin
               if (wb_first) begin
                  wb_first  <= 1'b0;
                  wb_data_q <= cache_data_i;
               end
               if (mem_ready_i) begin
                  if (cnt == LAST_WORD) begin
                     cnt        <= '0;
                     mem_req_o  <= 1'b1;
                     mem_rw_o   <= 1'b0;
                     mem_addr_o <= {miss_tag_q, {BW_OFF{1'b0}}};
                     state      <= S_FETCH;
                  end else begin
                     cnt        <= cnt + BW_OFF'(1);
                     mem_req_o  <= 1'b0;
                     mem_rw_o   <= 1'b0;
                     mem_addr_o <= '0;
                     cache_rd_o <= 1'b1;
                     state      <= S_WB_RD;
                  end
               end
            end

            S_FETCH: begin
               if (mem_ready_i) begin
                  mem_req_o  <= 1'b0;
                  mem_rw_o   <= 1'b0;
                  mem_addr_o <= '0;
                  cnt        <= '0;
                  state      <= S_FILL;
               end
            end

            S_FILL: begin
               if (mem_valid_i) begin
                  if (cnt == LAST_WORD) begin
                     cnt      <= '0;
                     tag_wr_o <= 1'b1;
                     state    <= S_COMMIT;
                  end else begin
                     cnt <= cnt + BW_OFF'(1);
                  end
               end
            end

            S_COMMIT: begin
               tag_wr_o <= 1'b0;
               done_o   <= 1'b1;
               state    <= S_DONE;
            end

            // A miss arriving here is dropped; the cache controller re-issues it.
            S_DONE: begin
               done_o <= 1'b0;
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef MISS_FILL_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] val);
      return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
   endfunction

   // Saturating event counters: accepted misses and completed block writebacks.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         stat_miss_o <= '0;
         stat_wb_o   <= '0;
      end else begin
         if ((state == S_IDLE) && miss_i) begin
            stat_miss_o <= sat_inc(stat_miss_o);
         end
         if ((state == S_WB_WR) && mem_ready_i && (cnt == LAST_WORD)) begin
            stat_wb_o <= sat_inc(stat_wb_o);
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_miss_fill_controller.sv
// Bench for cache_miss_fill_controller: a cycle table for a clean miss plus
// hand-driven sequences for writeback, backpressure, policy timing, reset
// abort and a miss arriving while busy.
module tb_cache_miss_fill_controller;

   logic        clock_i = 1'b0;
   logic        resetn_i;
   logic        miss_i;
   logic [23:0] miss_tag_i;
   logic        busy_o, done_o;
   logic [6:0]  line_o;
   logic        policy_miss_o, policy_done_i;
   logic [6:0]  policy_addr_i;
   logic        tag_rd_o, victim_valid_i, victim_dirty_i;
   logic [23:0] victim_tag_i;
   logic        tag_wr_o;
   logic [23:0] tag_o;
   logic [8:0]  cache_addr_o;
   logic        cache_rd_o;
   logic [31:0] cache_data_i;
   logic        cache_wr_o;
   logic [31:0] cache_data_o;
   logic        mem_req_o, mem_rw_o;
   logic [25:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_ready_i, mem_valid_i;
   logic [31:0] mem_data_i;
`ifdef MISS_FILL_STATS_EN
   logic [31:0] stat_miss_o, stat_wb_o;
`endif

   cache_miss_fill_controller dut (
      .clock_i(clock_i), .resetn_i(resetn_i),
      .miss_i(miss_i), .miss_tag_i(miss_tag_i),
      .busy_o(busy_o), .done_o(done_o), .line_o(line_o),
      .policy_miss_o(policy_miss_o), .policy_done_i(policy_done_i), .policy_addr_i(policy_addr_i),
      .tag_rd_o(tag_rd_o), .victim_valid_i(victim_valid_i), .victim_dirty_i(victim_dirty_i),
      .victim_tag_i(victim_tag_i), .tag_wr_o(tag_wr_o), .tag_o(tag_o),
      .cache_addr_o(cache_addr_o), .cache_rd_o(cache_rd_o), .cache_data_i(cache_data_i),
      .cache_wr_o(cache_wr_o), .cache_data_o(cache_data_o),
      .mem_req_o(mem_req_o), .mem_rw_o(mem_rw_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i),
      .mem_data_i(mem_data_i)
`ifdef MISS_FILL_STATS_EN
      , .stat_miss_o(stat_miss_o), .stat_wb_o(stat_wb_o)
`endif
   );

   always #5 clock_i = ~clock_i;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] all_outs();
      return {busy_o, done_o, line_o, policy_miss_o, tag_rd_o, tag_wr_o, tag_o,
              cache_addr_o, cache_rd_o, cache_wr_o, cache_data_o,
              mem_req_o, mem_rw_o, mem_addr_o, mem_data_o};
   endfunction

   // ---------------- clean-miss cycle table ----------------
   typedef struct {
      logic        miss, pdone;
      logic [6:0]  paddr;
      logic        vv, vd, mrdy, mval;
      logic [31:0] mdat;
      // {busy,done,policy_miss,tag_rd,tag_wr,cache_rd,cache_wr,mem_req,mem_rw}
      logic [8:0]  strb;
      logic [6:0]  line;
      logic [23:0] tag;
      logic [8:0]  caddr;
      logic [31:0] cdo;
      logic [25:0] maddr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic miss, input logic pdone, input logic [6:0] paddr,
                      input logic vv, input logic vd, input logic mrdy, input logic mval,
                      input logic [31:0] mdat, input logic [8:0] strb, input logic [6:0] line,
                      input logic [23:0] tag, input logic [8:0] caddr, input logic [31:0] cdo,
                      input logic [25:0] maddr);
      vec_t v;
      v.miss = miss; v.pdone = pdone; v.paddr = paddr; v.vv = vv; v.vd = vd;
      v.mrdy = mrdy; v.mval = mval; v.mdat = mdat; v.strb = strb; v.line = line;
      v.tag = tag; v.caddr = caddr; v.cdo = cdo; v.maddr = maddr;
      tbl.push_back(v);
   endtask

   // ---------------- sequence recorder ----------------
   logic [25:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [8:0]  fill_addr[$];
   logic [31:0] fill_data[$];
   int          n_pm, n_tagwr, n_done, n_rd, stable_err;
   bit          aborted, timed_out;
   logic [6:0]  done_line;
   logic [23:0] last_tag;
   logic [25:0] rd_addr;

   task automatic idle_inputs();
      miss_i = 1'b0; policy_done_i = 1'b0; policy_addr_i = '0;
      victim_valid_i = 1'b0; victim_dirty_i = 1'b0; victim_tag_i = '0;
      cache_data_i = '0; mem_ready_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0;
   endtask

   task automatic run_miss(input logic [23:0] mtag, input logic [6:0] paddr, input int pol_delay,
                           input bit pdone_early, input logic vvalid, input logic vdirty,
                           input logic [23:0] vtag, input int rdy_wait, input bit miss_in_wb,
                           input bit abort_fill);
      bit tag_pend, c_pend, filling, fin, wb_miss_sent;
      logic [8:0]  c_paddr;
      logic [25:0] hold_addr;
      logic [31:0] hold_data;
      int since_pm, waitc, words;
      tag_pend = 0; c_pend = 0; filling = 0; fin = 0; wb_miss_sent = 0;
      c_paddr = '0; hold_addr = '0; hold_data = '0;
      since_pm = -1; waitc = 0; words = 0;
      wr_addr.delete(); wr_data.delete(); fill_addr.delete(); fill_data.delete();
      n_pm = 0; n_tagwr = 0; n_done = 0; n_rd = 0; stable_err = 0;
      aborted = 0; timed_out = 0; done_line = '0; last_tag = '0; rd_addr = '0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         @(negedge clock_i);
         if (policy_miss_o) begin
            n_pm++;
            since_pm = 0;
         end else if (since_pm >= 0 && since_pm < 1000) begin
            since_pm++;
         end
         miss_i     = (cyc == 0);
         miss_tag_i = (cyc == 0) ? mtag : 24'hFFFFFF;
         if (miss_in_wb && !wb_miss_sent && mem_req_o && mem_rw_o) begin
            miss_i = 1'b1;
            wb_miss_sent = 1;
         end
         policy_done_i  = (since_pm == pol_delay) || (pdone_early && since_pm == 0);
         policy_addr_i  = (since_pm == pol_delay) ? paddr : 7'h2A;
         victim_valid_i = tag_pend & vvalid;
         victim_dirty_i = tag_pend & vdirty;
         victim_tag_i   = tag_pend ? vtag : 24'hABCDEF;
         cache_data_i   = c_pend ? (32'hB0 + 32'(c_paddr[1:0]) + ((c_paddr[8:2] == paddr) ? 32'h0 : 32'h100))
                                 : (32'hDEAD_0000 | 32'(cyc));
         mem_ready_i    = mem_req_o && (waitc >= rdy_wait);
         mem_valid_i    = filling && (words < 4);
         mem_data_i     = mem_valid_i ? (32'hA0 + 32'(words)) : 32'h55;
         #1;
         if (mem_req_o) begin
            if (waitc == 0) begin
               hold_addr = mem_addr_o;
               hold_data = mem_data_o;
            end else if (mem_addr_o !== hold_addr || mem_data_o !== hold_data) begin
               stable_err++;
            end
            if (mem_ready_i) begin
               if (mem_rw_o) begin
                  wr_addr.push_back(mem_addr_o);
                  wr_data.push_back(mem_data_o);
               end else begin
                  n_rd++;
                  rd_addr = mem_addr_o;
                  filling = 1;
               end
               waitc = 0;
            end else begin
               waitc++;
            end
         end
         if (cache_wr_o) begin
            fill_addr.push_back(cache_addr_o);
            fill_data.push_back(cache_data_o);
         end
         if (mem_valid_i) words++;
         if (tag_wr_o) begin
            n_tagwr++;
            last_tag = tag_o;
         end
         if (done_o) begin
            n_done++;
            done_line = line_o;
            fin = 1;
         end
         tag_pend = tag_rd_o;
         c_pend   = cache_rd_o;
         c_paddr  = cache_addr_o;
         if (abort_fill && words == 3) begin
            aborted = 1;
            fin = 1;
         end
      end
      if (!fin) timed_out = 1;
      idle_inputs();
   endtask

   task automatic check_complete(input string name, input logic [23:0] mtag, input logic [6:0] paddr);
      chk({name, " timeout"}, timed_out, 1'b0);
      chk({name, " fetch"}, {n_rd, rd_addr}, {32'd1, mtag, 2'b00});
      chk({name, " fill count"}, fill_addr.size(), 4);
      for (int i = 0; i < 4 && i < fill_addr.size(); i++) begin
         chk($sformatf("%s fill[%0d]", name, i), {fill_addr[i], fill_data[i]},
             {paddr, 2'(i), 32'hA0 + 32'(i)});
      end
      chk({name, " tag commit"}, {n_tagwr, last_tag}, {32'd1, mtag});
      chk({name, " done"}, {n_done, done_line}, {32'd1, paddr});
      chk({name, " policy pulses"}, n_pm, 1);
      @(negedge clock_i);
      #1;
      chk({name, " busy drop"}, {busy_o, done_o}, 2'b00);
   endtask

   task automatic check_wb(input string name, input logic [23:0] vtag);
      chk({name, " wb count"}, wr_addr.size(), 4);
      for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
         chk($sformatf("%s wb[%0d]", name, i), {wr_addr[i], wr_data[i]},
             {vtag, 2'(i), 32'hB0 + 32'(i)});
      end
      chk({name, " wb stable"}, stable_err, 0);
   endtask

`ifdef MISS_FILL_STATS_EN
   logic [31:0] sm0, sw0;
`endif

   initial begin
      resetn_i = 1'b0;
      miss_tag_i = '0;
      idle_inputs();
      repeat (3) @(negedge clock_i);
      #1;
      chk("reset outputs", all_outs(), '0);
      @(negedge clock_i);
      resetn_i = 1'b1;

      // clean miss, one row per cycle starting with the IDLE cycle carrying miss_i
      add(1,0,0, 0,0,0,0,32'h0,  9'b000000000, 7'd0, 24'h0,   9'h00, 32'h0,  26'h0);
      add(0,0,0, 0,0,0,0,32'h0,  9'b101000000, 7'd0, 24'h123, 9'h00, 32'h0,  26'h0);
      add(0,0,0, 0,0,0,0,32'h0,  9'b100000000, 7'd0, 24'h123, 9'h00, 32'h0,  26'h0);
      add(0,1,5, 0,0,0,0,32'h0,  9'b100000000, 7'd0, 24'h123, 9'h00, 32'h0,  26'h0);
      add(0,0,0, 0,0,0,0,32'h0,  9'b100100000, 7'd5, 24'h123, 9'h14, 32'h0,  26'h0);
      add(0,0,0, 1,0,0,1,32'hEE, 9'b100000000, 7'd5, 24'h123, 9'h14, 32'h0,  26'h0);
      add(0,0,0, 0,0,1,0,32'h0,  9'b100000010, 7'd5, 24'h123, 9'h14, 32'h0,  26'h48C);
      add(0,0,0, 0,0,0,1,32'hA0, 9'b100000100, 7'd5, 24'h123, 9'h14, 32'hA0, 26'h0);
      add(0,0,0, 0,0,0,1,32'hA1, 9'b100000100, 7'd5, 24'h123, 9'h15, 32'hA1, 26'h0);
      add(0,0,0, 0,0,0,1,32'hA2, 9'b100000100, 7'd5, 24'h123, 9'h16, 32'hA2, 26'h0);
      add(0,0,0, 0,0,0,1,32'hA3, 9'b100000100, 7'd5, 24'h123, 9'h17, 32'hA3, 26'h0);
      add(0,0,0, 0,0,0,0,32'h0,  9'b100010000, 7'd5, 24'h123, 9'h14, 32'h0,  26'h0);
      add(1,0,0, 0,0,0,0,32'h0,  9'b110000000, 7'd5, 24'h123, 9'h14, 32'h0,  26'h0);
      add(0,0,0, 0,0,0,0,32'h0,  9'b000000000, 7'd5, 24'h123, 9'h14, 32'h0,  26'h0);
      add(0,0,0, 0,0,0,0,32'h0,  9'b000000000, 7'd5, 24'h123, 9'h14, 32'h0,  26'h0);

      miss_tag_i = 24'h123;
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clock_i);
         miss_i = tbl[i].miss; policy_done_i = tbl[i].pdone; policy_addr_i = tbl[i].paddr;
         victim_valid_i = tbl[i].vv; victim_dirty_i = tbl[i].vd; victim_tag_i = 24'h0;
         cache_data_i = 32'h0; mem_ready_i = tbl[i].mrdy; mem_valid_i = tbl[i].mval;
         mem_data_i = tbl[i].mdat;
         #1;
         chk($sformatf("clean[%0d] strobes", i),
             {busy_o, done_o, policy_miss_o, tag_rd_o, tag_wr_o, cache_rd_o, cache_wr_o, mem_req_o, mem_rw_o},
             tbl[i].strb);
         chk($sformatf("clean[%0d] buses", i),
             {line_o, tag_o, cache_addr_o, cache_data_o, mem_addr_o, mem_data_o},
             {tbl[i].line, tbl[i].tag, tbl[i].caddr, tbl[i].cdo, tbl[i].maddr, 32'h0});
      end
      idle_inputs();

      // dirty victim, a second miss during WB_WR must be ignored
`ifdef MISS_FILL_STATS_EN
      sm0 = stat_miss_o; sw0 = stat_wb_o;
`endif
      run_miss(24'h000123, 7'd5, 2, 0, 1'b1, 1'b1, 24'h000777, 0, 1, 0);
      check_wb("dirty", 24'h000777);
      check_complete("dirty", 24'h000123, 7'd5);
`ifdef MISS_FILL_STATS_EN
      chk("stat miss delta", stat_miss_o - sm0, 32'd1);
      chk("stat wb delta", stat_wb_o - sw0, 32'd1);
`endif

      // memory holds ready low 3 cycles per request
      run_miss(24'h0ABCDE, 7'd77, 2, 0, 1'b1, 1'b1, 24'h0F0F0F, 3, 0, 0);
      check_wb("backpressure", 24'h0F0F0F);
      check_complete("backpressure", 24'h0ABCDE, 7'd77);

      // policy_done already high in POL; only the POL_WAIT value counts
      run_miss(24'h000042, 7'd51, 1, 1, 1'b1, 1'b0, 24'h0, 0, 0, 0);
      chk("policy early no wb", wr_addr.size(), 0);
      check_complete("policy early", 24'h000042, 7'd51);

      // dirty bit without valid bit is not a writeback
      run_miss(24'h000321, 7'd127, 2, 0, 1'b0, 1'b1, 24'h000999, 0, 0, 0);
      chk("invalid victim no wb", wr_addr.size(), 0);
      check_complete("invalid victim", 24'h000321, 7'd127);

      // reset after fill word 2
      run_miss(24'h000345, 7'd9, 2, 0, 1'b1, 1'b0, 24'h0, 0, 0, 1);
      chk("abort fill words", {aborted, 32'(fill_addr.size())}, {1'b1, 32'd3});
      @(negedge clock_i);
      resetn_i = 1'b0;
      #1;
      chk("abort outputs zero", all_outs(), '0);
      chk("abort no commit", {n_tagwr, n_done}, 64'h0);
      repeat (2) @(negedge clock_i);
      #1;
      chk("abort held zero", all_outs(), '0);
      @(negedge clock_i);
      resetn_i = 1'b1;
      run_miss(24'h000456, 7'd17, 2, 0, 1'b1, 1'b0, 24'h0, 0, 0, 0);
      check_complete("after abort", 24'h000456, 7'd17);
`ifdef MISS_FILL_STATS_EN
      chk("stats after reset", {stat_miss_o, stat_wb_o}, {32'd1, 32'd0});
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
